// File: rtl/output_dev_seg.sv
// Memory-mapped output device: DATA/CTRL store registers plus an 8-digit multiplexed seven-segment scanner.
// Define OUTDEV_BYTE_WRITE_EN to make stores honour the BE byte enables; otherwise every store writes the full word.
module output_dev_seg #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic        Addr,
  input  logic [3:0]  BE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  logic [31:0]      data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic [3:0]       curNibble;
  logic             blankDigit;

  function automatic logic [6:0] hexToSeg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef OUTDEV_BYTE_WRITE_EN
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (WE) begin
      if (!Addr) begin
        for (int i = 0; i < 4; i++) begin
          if (BE[i]) data_d[8*i +: 8] = DataIn[8*i +: 8];
        end
      end else if (BE[0]) begin
        ctrl_d = DataIn[1:0];
      end
    end
  end
`else
  logic unusedBe;
  assign unusedBe = ^BE;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (WE) begin
      if (!Addr) data_d = DataIn;
      else       ctrl_d = DataIn[1:0];
    end
  end
`endif

  // Free-running scan: the digit index advances once per SCAN_DIV clocks, independent of EN.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Digit 0 is never blanked, so an all-zero word still shows a single "0".
  always_comb begin
    curNibble  = data_q[{idx_q, 2'b00} +: 4];
    blankDigit = ctrl_q[1] && (idx_q != 3'd0) && ((data_q >> {idx_q, 2'b00}) == 32'd0);
    an_d       = 8'hFF;
    seg_d      = 8'hFF;
    if (ctrl_q[0] && !blankDigit) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = {1'b1, hexToSeg(curNibble)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 32'h0000_0000;
      ctrl_q <= 2'b01;
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign DataOut = Addr ? {30'd0, ctrl_q} : data_q;
  assign AN      = an_q;
  assign SEG     = seg_q;

endmodule

// File: tb/tb_output_dev_seg.sv
// Directed self-checking bench for output_dev_seg with a fast scan (SCAN_DIV=4).
// Pin expectations come from a scan-position tracker plus a constant hex table.
module tb_output_dev_seg;

  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 2;

  logic        clk;
  logic        rst;
  logic        WE;
  logic        Addr;
  logic [3:0]  BE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  int checks = 0;
  int errors = 0;

  int          mCnt;
  int          mIdx;
  logic [31:0] mData;
  logic [1:0]  mCtrl;

  logic [6:0] hexTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  output_dev_seg #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .WE(WE), .Addr(Addr), .BE(BE),
    .DataIn(DataIn), .DataOut(DataOut), .AN(AN), .SEG(SEG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {AN,SEG} for a given display state.
  function automatic logic [15:0] expectPins(input int idx, input logic [31:0] d, input logic [1:0] c);
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] upper;
    logic [3:0]  nib;
    an    = 8'hFF;
    seg   = 8'hFF;
    upper = d >> (4 * idx);
    nib   = upper[3:0];
    if (c[0] && !(c[1] && idx != 0 && upper == 32'd0)) begin
      an  = ~(8'd1 << idx);
      seg = {1'b1, hexTable[nib]};
    end
    return {an, seg};
  endfunction

  // One clock: drive inputs, predict pins from the pre-edge state, then check after the edge.
  task automatic applyStimulus(input logic we, input logic addr, input logic [3:0] be,
                               input logic [31:0] din, input bit chk);
    logic [15:0] exp;
    WE     = we;
    Addr   = addr;
    BE     = be;
    DataIn = din;
    exp = expectPins(mIdx, mData, mCtrl);
    if (we) begin
`ifdef OUTDEV_BYTE_WRITE_EN
      if (!addr) begin
        for (int i = 0; i < 4; i++) if (be[i]) mData[8*i +: 8] = din[8*i +: 8];
      end else if (be[0]) begin
        mCtrl = din[1:0];
      end
`else
      if (!addr) mData = din;
      else       mCtrl = din[1:0];
`endif
    end
    if (mCnt == SCAN_DIV - 1) begin
      mCnt = 0;
      mIdx = (mIdx + 1) % 8;
    end else begin
      mCnt++;
    end
    @(posedge clk);
    #1;
    WE = 1'b0;
    if (chk) begin
      checkOutput("AN", {24'd0, AN}, {24'd0, exp[15:8]});
      checkOutput("SEG", {24'd0, SEG}, {24'd0, exp[7:0]});
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, Addr, 4'hF, 32'd0, 1'b1);
  endtask

  initial begin
    rst    = 1'b0;
    WE     = 1'b0;
    Addr   = 1'b0;
    BE     = 4'hF;
    DataIn = 32'd0;

    #2 rst = 1'b1;
    #1;
    checkOutput("rst_AN", {24'd0, AN}, 32'h0000_00FF);
    checkOutput("rst_SEG", {24'd0, SEG}, 32'h0000_00FF);
    checkOutput("rst_DATA", DataOut, 32'h0000_0000);
    Addr = 1'b1;
    #1;
    checkOutput("rst_CTRL", DataOut, 32'h0000_0001);
    Addr = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    mCnt  = 0;
    mIdx  = 0;
    mData = 32'h0;
    mCtrl = 2'b01;

    // Full scan over a word with distinct nibbles.
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h1234_5678, 1'b1);
    checkOutput("data_readback", DataOut, 32'h1234_5678);
    idleCycles(36);
    checkOutput("data_hold", DataOut, 32'h1234_5678);

    // Disable, let the scan run on, then re-enable mid-scan.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 1'b1);
    checkOutput("ctrl_off_read", DataOut, 32'h0000_0000);
    idleCycles(10);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h0000_0001, 1'b1);
    checkOutput("ctrl_on_read", DataOut, 32'h0000_0001);
    idleCycles(8);

    // Leading-zero blanking.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1);
    checkOutput("ctrl_upper_ignored", DataOut, 32'h0000_0003);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_00A5, 1'b1);
    checkOutput("data_a5", DataOut, 32'h0000_00A5);
    idleCycles(36);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_0000, 1'b1);
    checkOutput("data_zero", DataOut, 32'h0000_0000);
    idleCycles(36);

    // Write landing exactly on a scan wrap.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 8 && mCnt != SCAN_DIV - 1; i++) idleCycles(1);
    checkOutput("wrap_align", mCnt, SCAN_DIV - 1);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h9ABC_DEF0, 1'b1);
    checkOutput("wrap_write", DataOut, 32'h9ABC_DEF0);
    idleCycles(10);

`ifdef OUTDEV_BYTE_WRITE_EN
    applyStimulus(1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0101, 32'h0000_0000, 1'b1);
    checkOutput("byte_write", DataOut, 32'hFF00_FF00);
    applyStimulus(1'b1, 1'b0, 4'b0000, 32'h1234_5678, 1'b1);
    checkOutput("byte_none", DataOut, 32'hFF00_FF00);
    applyStimulus(1'b1, 1'b1, 4'b1110, 32'h0000_0000, 1'b1);
    checkOutput("byte_ctrl_skip", DataOut, 32'h0000_0001);
    idleCycles(8);
`endif

    // Asynchronous reset in the middle of a cycle with the display lit.
    Addr = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_AN", {24'd0, AN}, 32'h0000_00FF);
    checkOutput("midrst_SEG", {24'd0, SEG}, 32'h0000_00FF);
    checkOutput("midrst_DATA", DataOut, 32'h0000_0000);
    Addr = 1'b1;
    #1;
    checkOutput("midrst_CTRL", DataOut, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
